ex_mem_branch_stage: RTL and testbench

- Execute-to-memory boundary of the 5-stage pipeline; consumes the combinational ALU outputs (data_result, isNotEqual, isLessThan) and the ID/EX control fields.
- Registers everything into the EX/MEM latch.
- Resolves bne/blt and issues a registered PC redirect.
- Squashes the wrong-path instruction slots that follow a taken branch, and honours memory-stage stalls.

---
 rtl/ex_mem_branch_stage_pkg.sv | 24 ++
 rtl/ex_mem_branch_stage_squash_ctrl.sv | 52 +++++
 rtl/ex_mem_branch_stage.sv | 102 ++++++++++
 tb/tb_ex_mem_branch_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_branch_stage_pkg.sv
// Shared constants for the EX/MEM boundary: opcodes, link register, squash FSM states.
package ex_mem_branch_stage_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JAL   = 5'b00011;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } sq_state_e;

    // Opcodes that produce a register writeback (before the rd==0 filter).
    function automatic logic op_writes(input logic [4:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/ex_mem_branch_stage_squash_ctrl.sv
// Wrong-path squash FSM: after a taken branch, drops the next WRONG_PATH
// non-stalled slots, then returns to normal execution.
module squash_ctrl
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int WRONG_PATH = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic advance,
    input  logic taken,
    output logic squash
);

    sq_state_e  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // State and counter registers; reset may land mid-squash and clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: only non-stalled cycles move the FSM or consume a squash slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (advance) begin
            case (state_q)
                ST_RUN: begin
                    if (taken) begin
                        state_d = ST_SQUASH;
                        cnt_d   = 3'(WRONG_PATH);
                    end
                end
                ST_SQUASH: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign squash = (state_q == ST_SQUASH);

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline latch with bne/blt resolution, registered PC redirect and
// wrong-path squashing; the whole latch freezes while the memory stage stalls.
module ex_mem_branch_stage
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int WRONG_PATH = 3,
    parameter int PC_W       = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [4:0]      in_opcode,
    input  logic [4:0]      in_aluop,
    input  logic [4:0]      in_rd,
    input  logic [PC_W-1:0] in_pc,
    input  logic [16:0]     in_imm,
    input  logic [31:0]     in_store_data,
    input  logic [31:0]     alu_result,
    input  logic            alu_ne,
    input  logic            alu_lt,
    input  logic            mem_stall,
    output logic            in_ready,
    output logic            out_valid,
    output logic [4:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic [31:0]     out_result,
    output logic [31:0]     out_store_data,
    output logic            branch_taken,
    output logic [PC_W-1:0] branch_target
);

    logic            squash, live, cond, taken, we_d;
    logic [4:0]      rd_d;
    logic [PC_W-1:0] pc_inc, target_d;
    logic [31:0]     result_d;

    // The ALU opcode has no consumer past EX.
    logic unused_aluop;
    assign unused_aluop = ^in_aluop;

    logic            valid_q, we_q, taken_q;
    logic [4:0]      opcode_q, rd_q;
    logic [31:0]     result_q, sdata_q;
    logic [PC_W-1:0] target_q;

    squash_ctrl #(.WRONG_PATH(WRONG_PATH)) u_squash (
        .clock  (clock),
        .reset  (reset),
        .advance(!mem_stall),
        .taken  (taken),
        .squash (squash)
    );

    // Branch resolution, link value and writeback qualification for the incoming slot.
    always_comb begin
        live     = in_valid && !squash;
        cond     = ((in_opcode == OP_BNE) && alu_ne) || ((in_opcode == OP_BLT) && alu_lt);
        taken    = live && cond;
        pc_inc   = in_pc + PC_W'(1);
        target_d = pc_inc + {{(PC_W-17){in_imm[16]}}, in_imm};
        rd_d     = (in_opcode == OP_JAL) ? LINK_REG : in_rd;
        result_d = (in_opcode == OP_JAL) ? 32'(pc_inc) : alu_result;
        we_d     = live && op_writes(in_opcode) && (rd_d != 5'd0);
    end

    // EX/MEM latch: holds on stall, but the redirect pulse never lingers across one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            taken_q  <= 1'b0;
            opcode_q <= 5'd0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            sdata_q  <= 32'd0;
            target_q <= '0;
        end else if (mem_stall) begin
            taken_q  <= 1'b0;
        end else begin
            valid_q  <= live;
            we_q     <= we_d;
            taken_q  <= taken;
            opcode_q <= in_opcode;
            rd_q     <= rd_d;
            result_q <= result_d;
            sdata_q  <= in_store_data;
            target_q <= target_d;
        end
    end

    assign in_ready       = !mem_stall;
    assign out_valid      = valid_q;
    assign out_we         = we_q;
    assign out_opcode     = opcode_q;
    assign out_rd         = rd_q;
    assign out_result     = result_q;
    assign out_store_data = sdata_q;
    assign branch_taken   = taken_q;
    assign branch_target  = target_q;

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Bench for ex_mem_branch_stage: directed scenarios plus random traffic,
// compared against a slot-counting reference model.
module tb_ex_mem_branch_stage;

    logic        clock, reset;
    logic        in_valid, alu_ne, alu_lt, mem_stall;
    logic [4:0]  in_opcode, in_aluop, in_rd;
    logic [31:0] in_pc, in_store_data, alu_result;
    logic [16:0] in_imm;
    logic        in_ready, out_valid, out_we, branch_taken;
    logic [4:0]  out_opcode, out_rd;
    logic [31:0] out_result, out_store_data, branch_target;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic        m_valid, m_we, m_bt;
    logic [4:0]  m_op, m_rd;
    logic [31:0] m_res, m_sd, m_tgt;
    int          m_skip;

    ex_mem_branch_stage #(.WRONG_PATH(3), .PC_W(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_aluop(in_aluop), .in_rd(in_rd), .in_pc(in_pc), .in_imm(in_imm),
        .in_store_data(in_store_data), .alu_result(alu_result), .alu_ne(alu_ne),
        .alu_lt(alu_lt), .mem_stall(mem_stall), .in_ready(in_ready),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_we(out_we), .out_result(out_result), .out_store_data(out_store_data),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_we = 0; m_bt = 0; m_op = 0; m_rd = 0;
        m_res = 0; m_sd = 0; m_tgt = 0; m_skip = 0;
    endtask

    // One clock edge of the architectural behaviour, from the instruction-level rules.
    task automatic model_step();
        logic   v, tk;
        longint t, simm;
        if (reset) begin
            model_clear();
        end else if (mem_stall) begin
            m_bt = 0;
        end else begin
            v = in_valid && (m_skip == 0);
            if (m_skip > 0) m_skip--;
            tk = v && (((in_opcode == 5'd2) && alu_ne) || ((in_opcode == 5'd6) && alu_lt));
            m_valid = v;
            m_bt    = tk;
            m_op    = in_opcode;
            m_rd    = (in_opcode == 5'd3) ? 5'd31 : in_rd;
            m_we    = v && (in_opcode inside {5'd0, 5'd5, 5'd8, 5'd3}) && (m_rd != 0);
            t       = longint'(in_pc) + 1;
            m_res   = (in_opcode == 5'd3) ? t[31:0] : alu_result;
            m_sd    = in_store_data;
            if (tk) begin
                simm  = longint'(in_imm);
                if (simm >= 65536) simm = simm - 131072;
                t     = longint'(in_pc) + 1 + simm;
                m_tgt = t[31:0];
                m_skip = 3;
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", {31'd0, in_ready}, {31'd0, !mem_stall});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_we", {31'd0, out_we}, {31'd0, m_we});
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, m_bt});
        if (m_bt) chk("branch_target", branch_target, m_tgt);
        if (m_valid) begin
            chk("out_opcode", {27'd0, out_opcode}, {27'd0, m_op});
            chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
            chk("out_result", out_result, m_res);
            chk("out_store_data", out_store_data, m_sd);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_we"}, {31'd0, out_we}, 32'd0);
        chk({tag, "_bt"}, {31'd0, branch_taken}, 32'd0);
        chk({tag, "_result"}, out_result, 32'd0);
        chk({tag, "_sdata"}, out_store_data, 32'd0);
        chk({tag, "_rd"}, {27'd0, out_rd}, 32'd0);
        chk({tag, "_op"}, {27'd0, out_opcode}, 32'd0);
        chk({tag, "_tgt"}, branch_target, 32'd0);
    endtask

    // Inputs are set around the negedge; the model advances on the posedge.
    task automatic cyc();
        @(posedge clock);
        model_step();
        #1 compare();
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [16:0] imm,
                         input logic [31:0] res, input logic ne, input logic lt,
                         input logic stall);
        in_valid = v; in_opcode = op; in_rd = rd; in_pc = pc; in_imm = imm;
        alu_result = res; alu_ne = ne; alu_lt = lt; mem_stall = stall;
        in_aluop = op ^ 5'h0A;
        in_store_data = $urandom;
    endtask

    logic [4:0] ops [9] = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 6'd6, 5'd3, 5'd1, 5'd31};

    initial begin
        model_clear();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk_zero("rst");
        reset = 1'b0;

        // addi rd=5 result=0x10
        drive(1, 5'd5, 5'd5, 32'h4, 17'h0, 32'h10, 0, 0, 0); cyc();
        chk("addi_result", out_result, 32'h10);

        // taken bne at pc 0x20, imm -4, then valid, valid, bubble, valid
        drive(1, 5'd2, 5'd0, 32'h20, 17'h1FFFC, 32'h0, 1, 0, 0); cyc();
        chk("bne_target", branch_target, 32'h1D);
        drive(1, 5'd5, 5'd6, 32'h21, 0, 32'h11, 0, 0, 0); cyc();
        drive(1, 5'd0, 5'd7, 32'h22, 0, 32'h12, 0, 0, 0); cyc();
        drive(0, 5'd0, 5'd8, 32'h23, 0, 32'h13, 0, 0, 0); cyc();
        drive(1, 5'd5, 5'd9, 32'h1D, 0, 32'h14, 0, 0, 0); cyc();
        chk("post_squash_valid", {31'd0, out_valid}, 32'd1);

        // not-taken blt, following instruction not squashed
        drive(1, 5'd6, 5'd3, 32'h40, 17'h10, 32'h0, 1, 0, 0); cyc();
        drive(1, 5'd8, 5'd4, 32'h41, 0, 32'h99, 0, 0, 0); cyc();

        // taken bne held by a 2-cycle stall, then stalls inside the squash window
        drive(1, 5'd2, 5'd1, 32'h100, 17'h8, 32'h0, 1, 0, 1); cyc(); cyc();
        drive(1, 5'd2, 5'd1, 32'h100, 17'h8, 32'h0, 1, 0, 0); cyc();
        drive(1, 5'd5, 5'd2, 32'h101, 0, 32'h5, 0, 0, 0); cyc();
        drive(1, 5'd5, 5'd2, 32'h102, 0, 32'h6, 0, 0, 1); cyc(); cyc(); cyc();
        drive(1, 5'd5, 5'd2, 32'h102, 0, 32'h6, 0, 0, 0); cyc(); cyc();
        drive(1, 5'd5, 5'd2, 32'h103, 0, 32'h7, 0, 0, 0); cyc();

        // jal with rd=0 links to r31; R-type to r0 does not write
        drive(1, 5'd3, 5'd0, 32'h7FF, 0, 32'hDEAD, 0, 0, 0); cyc();
        chk("jal_result", out_result, 32'h800);
        drive(1, 5'd0, 5'd0, 32'h800, 0, 32'h1234, 0, 0, 0); cyc();

        // asynchronous reset with two squash slots left
        drive(1, 5'd6, 5'd0, 32'h200, 17'h3, 32'h0, 0, 1, 0); cyc();
        drive(1, 5'd5, 5'd3, 32'h201, 0, 32'h1, 0, 0, 0); cyc();
        #2 reset = 1'b1;
        #1 chk_zero("async_rst");
        model_clear();
        @(negedge clock);
        cyc();
        reset = 1'b0;
        drive(1, 5'd5, 5'd3, 32'h300, 0, 32'h77, 0, 0, 0); cyc();
        chk("after_rst_valid", {31'd0, out_valid}, 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 8)],
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, 17'($urandom), $urandom,
                  1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
